dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (I) and the load/store requester (D).
- One transaction is outstanding at a time. The block latches the winning request and drives it to memory until the memory acknowledges or a timeout fires.
- It returns a one-cycle completion pulse with read data, and drives stall signals back to the pipeline.
- Sits between the fetch/memory stages and the shared memory model or bus bridge.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with D over I.
- TIMEOUT_CYCLES, 16, maximum cycles spent in BUSY before an error completion; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_req  input  1  fetch request; held until i_done
- i_addr  input  ADDR_WIDTH  fetch address
- i_done  output  1  one-cycle completion pulse to fetch
- i_rdata  output  DATA_WIDTH  fetch read data; valid while i_done
- i_err  output  1  fetch timeout error; valid while i_done
- i_stall  output  1  i_req & ~i_done
- d_req  input  1  load/store request; held until d_done
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_WIDTH  load/store address
- d_wdata  input  DATA_WIDTH  store data
- d_wstrb  input  DATA_WIDTH/8  store byte enables
- d_done  output  1  one-cycle completion pulse to load/store
- d_rdata  output  DATA_WIDTH  load data; valid while d_done
- d_err  output  1  load/store timeout error; valid while d_done
- d_stall  output  1  d_req & ~d_done
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_wstrb  output  DATA_WIDTH/8  memory byte enables
- mem_ack  input  1  memory completion; single-cycle pulse
- mem_rdata  input  DATA_WIDTH  memory read data; valid with mem_ack
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to IDLE; last_grant = I; timeout counter = 0.
  - Reset asserted mid-transaction drops mem_req immediately (asynchronous). No done pulse is produced for the aborted transaction.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If i_req or d_req at a posedge: select the winner, register winner id, addr, we, wdata and wstrb, clear the counter, and go to BUSY.
  - The I port always registers we=0 and wstrb=0.
- Arbitration when both ports request:
  - RR_MODE=0: D wins.
  - RR_MODE=1: the port that did not win last wins.
  - A single requester always wins. last_grant updates on every grant.
- BUSY:
  - mem_req=1; mem_* outputs come from the registers and are stable for the whole state.
  - On mem_ack, capture mem_rdata, set err=0, go to RESP.
  - Otherwise increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without ack, set rdata=0, err=1, go to RESP.
  - If mem_ack arrives in the same cycle as the timeout, the ack wins (err=0).
- RESP:
  - mem_req=0. The winner's done=1 with rdata and err; the other port's done, rdata and err are 0.
  - Next state is unconditionally IDLE.
  - Requesters must drop or update req on the edge where done is seen. The IDLE cycle after RESP re-arbitrates.
- Latency:
  - Request seen at edge 0 gives mem_req from cycle 1.
  - mem_ack in cycle n gives done in cycle n+1.
  - Minimum request-to-done is 2 cycles; back-to-back grant period is 3 cycles plus memory latency.
- Changes to the unselected port's inputs during BUSY or RESP have no effect. The selected port's input changes are ignored after latching.
- mem_ack received outside BUSY is ignored.
- A request dropped before it is granted is simply not served. There is no queueing.
- busy = (state ≠ IDLE). The stall outputs are combinational from req and done.

Test Plan:
- Reset, then I only:
  - Stimulus: i_req=1, i_addr=0x100; memory acks 1 cycle after mem_req with mem_rdata=0xDEADBEEF.
  - Required: mem_req in cycle 1, i_done in cycle 2 with i_rdata=0xDEADBEEF and i_err=0; i_stall high during cycles 0–1.
- D store:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0x12345678, d_wstrb=4'b0011; ack delayed 3 cycles.
  - Required: mem_we=1 and mem_wstrb=0011 held stable for all 4 BUSY cycles; d_done a single pulse; mem_req low in RESP.
- Contention with I and D held continuously:
  - RR_MODE=1: grants alternate D, I, D, I, since last_grant=I after reset.
  - RR_MODE=0: D wins every time while d_req is held.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, no mem_ack.
  - Required: exactly 4 BUSY cycles, then d_done=1, d_err=1, d_rdata=0; a later mem_ack in IDLE is ignored.
- Ack and timeout in the same cycle: mem_ack asserted in the final BUSY cycle gives err=0 and the captured data.
- Reset mid-BUSY: rst_n low during BUSY forces mem_req=0 and busy=0 immediately; no done pulse after release; the next request is served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) requesters onto one single-port memory,
// one outstanding transaction at a time, with optional round-robin and a BUSY timeout.
module dmem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned RR_MODE        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_req,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   output logic                      i_done,
   output logic [DATA_WIDTH-1:0]     i_rdata,
   output logic                      i_err,
   output logic                      i_stall,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [ADDR_WIDTH-1:0]     d_addr,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
   output logic                      d_done,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   output logic                      d_err,
   output logic                      d_stall,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
   input  logic                      mem_ack,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy
);

   localparam int unsigned STRB_W     = DATA_WIDTH / 8;
   localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);
   localparam bit          FIXED_PRIO = (RR_MODE == 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    win_d_q, win_d_d;    // 1 = D owns the current transaction
   logic                    last_d_q, last_d_d;  // 1 = D won the most recent grant
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    pick_d;

   // State and transaction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         win_d_q  <= 1'b0;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         win_d_q  <= win_d_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state: grant in IDLE, wait for ack or timeout in BUSY, one response cycle
   always_comb begin
      state_d  = state_q;
      win_d_d  = win_d_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      pick_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               // D wins alone, under fixed priority, or when I had the last grant
               pick_d   = d_req && (!i_req || FIXED_PRIO || !last_d_q);
               win_d_d  = pick_d;
               last_d_d = pick_d;
               addr_d   = pick_d ? d_addr : i_addr;
               we_d     = pick_d && d_we;
               wdata_d  = pick_d ? d_wdata : '0;
               wstrb_d  = pick_d ? d_wstrb : '0;
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Memory side is driven only while BUSY
   assign busy      = (state_q != ST_IDLE);
   assign mem_req   = (state_q == ST_BUSY);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = mem_req ? addr_q  : '0;
   assign mem_wdata = mem_req ? wdata_q : '0;
   assign mem_wstrb = mem_req ? wstrb_q : '0;

   // Completion goes only to the owner of the transaction
   assign i_done  = (state_q == ST_RESP) && !win_d_q;
   assign d_done  = (state_q == ST_RESP) &&  win_d_q;
   assign i_rdata = i_done ? rdata_q : '0;
   assign d_rdata = d_done ? rdata_q : '0;
   assign i_err   = i_done && err_q;
   assign d_err   = d_done && err_q;
   assign i_stall = i_req && !i_done;
   assign d_stall = d_req && !d_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for contention and reset,
// then random transactions checked against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int          TO = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic i_req, d_req, d_we, mem_ack;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic [SW-1:0] d_wstrb;

   logic i_done, i_err, i_stall, d_done, d_err, d_stall, mem_req, mem_we, busy;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [SW-1:0] mem_wstrb;

   logic fp_i_done, fp_i_err, fp_i_stall, fp_d_done, fp_d_err, fp_d_stall;
   logic fp_mem_req, fp_mem_we, fp_busy, fp_mem_ack;
   logic [DW-1:0] fp_i_rdata, fp_d_rdata, fp_mem_wdata;
   logic [AW-1:0] fp_mem_addr;
   logic [SW-1:0] fp_mem_wstrb;

   int n_cmp = 0;
   int n_bad = 0;
   bit last_d_m;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
      .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Fixed-priority instance with an always-ready memory
   assign fp_mem_ack = fp_mem_req;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT_CYCLES(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(fp_i_done), .i_rdata(fp_i_rdata),
      .i_err(fp_i_err), .i_stall(fp_i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_done(fp_d_done), .d_rdata(fp_d_rdata), .d_err(fp_d_err), .d_stall(fp_d_stall),
      .mem_req(fp_mem_req), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
      .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb), .mem_ack(fp_mem_ack),
      .mem_rdata(mem_rdata), .busy(fp_busy)
   );

   typedef struct {
      logic          ireq, dreq, dwe;
      logic [AW-1:0] iaddr, daddr;
      logic [DW-1:0] dwdata;
      logic [SW-1:0] dwstrb;
      int            ack_at;     // BUSY cycle (1-based) in which memory acks; 0 = never
      logic [DW-1:0] ack_data;
      logic          stray;      // pulse mem_ack once while idle afterwards
      logic          exp_d;
      int            exp_lat;    // cycles from the grant edge to the done cycle
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   function automatic vec_t mk(logic ireq, logic dreq, logic dwe, logic [AW-1:0] iaddr,
                               logic [AW-1:0] daddr, logic [DW-1:0] dwdata,
                               logic [SW-1:0] dwstrb, int ack_at, logic [DW-1:0] ack_data,
                               logic stray, logic exp_d, int exp_lat,
                               logic [DW-1:0] exp_rdata, logic exp_err);
      vec_t v;
      v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.iaddr = iaddr; v.daddr = daddr;
      v.dwdata = dwdata; v.dwstrb = dwstrb; v.ack_at = ack_at; v.ack_data = ack_data;
      v.stray = stray; v.exp_d = exp_d; v.exp_lat = exp_lat; v.exp_rdata = exp_rdata;
      v.exp_err = exp_err;
      return v;
   endfunction

   // Reference: grant rule plus "ack within TO busy cycles, else timeout error"
   function automatic vec_t ref_fill(vec_t v, bit last_d);
      vec_t r = v;
      r.exp_d = v.dreq && (!v.ireq || !last_d);
      if (v.ack_at >= 1 && v.ack_at <= TO) begin
         r.exp_lat = v.ack_at + 1; r.exp_rdata = v.ack_data; r.exp_err = 1'b0;
      end else begin
         r.exp_lat = TO + 1; r.exp_rdata = '0; r.exp_err = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, 256'({mem_req, i_done, d_done, busy}), 256'(4'b0000));
   endtask

   // Runs one transaction from an idle negedge and leaves the bench at an idle negedge
   task automatic run_txn(input vec_t v);
      logic [DW-1:0] wd;
      i_req = v.ireq; i_addr = v.iaddr;
      d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata; d_wstrb = v.dwstrb;
      mem_ack = 1'b0;
      #1 check("stall_c0", 256'({i_stall, d_stall}), 256'({v.ireq, v.dreq}));
      for (int cyc = 1; cyc <= v.exp_lat; cyc++) begin
         @(negedge clk);
         if (cyc < v.exp_lat) begin
            wd = v.exp_d ? mem_wdata : '0;
            check("busy_cyc",
                  256'({mem_req, mem_we, mem_addr, wd, mem_wstrb, i_done, d_done, busy,
                        i_stall, d_stall}),
                  256'({1'b1, v.exp_d & v.dwe, (v.exp_d ? v.daddr : v.iaddr),
                        (v.exp_d ? v.dwdata : {DW{1'b0}}), (v.exp_d ? v.dwstrb : {SW{1'b0}}),
                        1'b0, 1'b0, 1'b1, v.ireq, v.dreq}));
         end else begin
            check("done_cyc",
                  256'({mem_req, i_done, d_done, i_rdata, i_err, d_rdata, d_err, busy,
                        i_stall, d_stall}),
                  256'({1'b0, !v.exp_d, v.exp_d, (v.exp_d ? {DW{1'b0}} : v.exp_rdata),
                        !v.exp_d & v.exp_err, (v.exp_d ? v.exp_rdata : {DW{1'b0}}),
                        v.exp_d & v.exp_err, 1'b1, v.ireq & v.exp_d, v.dreq & !v.exp_d}));
            i_req = 1'b0; d_req = 1'b0;
         end
         mem_ack   = (cyc == v.ack_at);
         mem_rdata = mem_ack ? v.ack_data : $urandom();
      end
      @(negedge clk);
      mem_ack = 1'b0;
      check_idle("idle_after");
      if (v.stray) begin
         mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         mem_ack = 1'b0;
         check_idle("stray_ack");
      end
      last_d_m = v.exp_d;
   endtask

   vec_t vecs [9];

   initial begin
      vec_t v;
      int ndone, last_cyc, fp_i, fp_d;
      logic [1:0] r;

      vecs[0] = mk(1, 0, 0, 32'h100, 32'h0,   32'h0,        4'b0000, 1, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF, 0);
      vecs[1] = mk(0, 1, 1, 32'h0,   32'h200, 32'h12345678, 4'b0011, 4, 32'hCAFEF00D, 0, 1, 5, 32'hCAFEF00D, 0);
      vecs[2] = mk(0, 1, 0, 32'h0,   32'h204, 32'h0,        4'b0000, 2, 32'h0BADF00D, 0, 1, 3, 32'h0BADF00D, 0);
      vecs[3] = mk(1, 1, 0, 32'h104, 32'h208, 32'h0,        4'b0000, 1, 32'h11111111, 0, 0, 2, 32'h11111111, 0);
      vecs[4] = mk(1, 1, 0, 32'h108, 32'h20C, 32'h0,        4'b0000, 3, 32'h22222222, 0, 1, 4, 32'h22222222, 0);
      vecs[5] = mk(0, 1, 1, 32'h0,   32'h210, 32'hA5A5A5A5, 4'b1111, 0, 32'h0,        1, 1, 5, 32'h0,        1);
      vecs[6] = mk(1, 0, 0, 32'h10C, 32'h0,   32'h0,        4'b0000, 0, 32'h0,        0, 0, 5, 32'h0,        1);
      vecs[7] = mk(1, 1, 1, 32'h110, 32'h214, 32'h55AA55AA, 4'b0101, 4, 32'h33333333, 0, 1, 5, 32'h33333333, 0);
      vecs[8] = mk(1, 1, 0, 32'h114, 32'h218, 32'h0,        4'b0000, 5, 32'h44444444, 1, 0, 5, 32'h0,        1);

      rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
      last_d_m = 1'b0;
      @(negedge clk); @(negedge clk);
      check("reset_rr", 256'({i_done, i_rdata, i_err, i_stall, d_done, d_rdata, d_err, d_stall,
                              mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy}), 256'(0));
      check("reset_fp", 256'({fp_i_done, fp_i_rdata, fp_i_err, fp_i_stall, fp_d_done,
                              fp_d_rdata, fp_d_err, fp_d_stall, fp_mem_req, fp_mem_we,
                              fp_mem_addr, fp_mem_wdata, fp_mem_wstrb, fp_busy}), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 9; k++) run_txn(vecs[k]);

      // Both ports held: RR alternates starting from the port that did not win last
      repeat (3) @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h400; d_addr = 32'h500;
      ndone = 0; last_cyc = 0; fp_i = 0; fp_d = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (fp_i_done) fp_i++;
         if (fp_d_done) fp_d++;
         if (i_done || d_done) begin
            check("rr_grant", 256'({i_done, d_done}), 256'({last_d_m, !last_d_m}));
            last_d_m = !last_d_m;
            if (ndone > 0) check("rr_period", 256'(cyc - last_cyc), 256'(3));
            last_cyc = cyc;
            ndone++;
         end
         mem_ack = mem_req;
         if (ndone == 4) break;
      end
      check("rr_count", 256'(ndone), 256'(4));
      check("fp_d_wins", 256'({fp_i, fp_d}), 256'({32'd0, 32'd4}));
      i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk); @(negedge clk);
      check_idle("after_contention");

      // Reset in the middle of BUSY aborts silently
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h77; d_wstrb = 4'b1000;
      @(negedge clk); @(negedge clk);
      check("pre_reset_busy", 256'({mem_req, busy}), 256'(2'b11));
      #2 rst_n = 1'b0;
      #1 check("reset_async", 256'({mem_req, busy, d_done, i_done}), 256'(4'b0000));
      d_req = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_idle("post_reset");
      end
      last_d_m = 1'b0;
      v = mk(1, 1, 0, 32'h600, 32'h700, 32'h0, 4'b0000, 2, 32'h89ABCDEF, 0, 0, 0, 32'h0, 0);
      run_txn(ref_fill(v, last_d_m));

      // Random transactions against the reference model
      for (int k = 0; k < 40; k++) begin
         r = 2'($urandom_range(1, 3));
         v = mk(r[0], r[1], 1'($urandom()), $urandom(), $urandom(), $urandom(),
                4'($urandom()), int'($urandom_range(0, 6)), $urandom(), 1'($urandom()),
                0, 0, 32'h0, 0);
         run_txn(ref_fill(v, last_d_m));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
